// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: synchronizes rstz, then releases NUM_RST active-low resets in index order,
// with a four-phase sw_req/sw_ack handshake that re-runs the whole sequence from RUN.
module rst_seq_ctrl #(
  parameter int DEPTH   = 2,
  parameter int NUM_RST = 4,
  parameter int HOLD    = 8,
  parameter int GAP     = 16
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic               sw_req,
  output logic               sw_ack,
  output logic [NUM_RST-1:0] rst_out_n,
  output logic               busy,
  output logic               ready
);
  localparam int CW = $clog2((HOLD > GAP ? HOLD : GAP) + 1);
  localparam int IW = NUM_RST > 1 ? $clog2(NUM_RST) : 1;
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(NUM_RST - 1);
  typedef enum logic [1:0] {S_HOLD, S_REL, S_RUN} state_t;
  logic [DEPTH-1:0]   sync_q;
  logic               srst_n;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               pend_q, pend_d;
  logic               sw_ack_q, sw_ack_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) sync_q <= '0;
    else       sync_q <= {sync_q[DEPTH-2:0], 1'b1};
  end
  assign srst_n = sync_q[DEPTH-1];
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    pend_d   = pend_q;
    sw_ack_d = sw_ack_q & sw_req;
    rst_d    = rst_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    if (!srst_n) begin
      state_d  = S_HOLD;
      cnt_d    = '0;
      idx_d    = '0;
      pend_d   = 1'b0;
      sw_ack_d = 1'b0;
      rst_d    = '0;
      busy_d   = 1'b1;
      ready_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: if (cnt_q == HOLD_END) begin
          state_d = S_REL;
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = NUM_RST'({rst_q, 1'b1});
        end
        S_REL: if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (idx_q == IDX_END) begin
            state_d  = S_RUN;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
            sw_ack_d = pend_q | sw_ack_d;
            pend_d   = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            // released bits form a contiguous run from bit 0, so shifting in a 1 frees the next index
            rst_d = NUM_RST'({rst_q, 1'b1});
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (sw_req && !sw_ack_q) begin
            state_d = S_HOLD;
            pend_d  = 1'b1;
            rst_d   = '0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      sw_ack_q <= 1'b0;
      rst_q    <= '0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      sw_ack_q <= sw_ack_d;
      rst_q    <= rst_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end
  assign sw_ack    = sw_ack_q;
  assign rst_out_n = rst_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: random req/reset stimulus on a default and a minimal instance,
// checked against a timeline model (outputs derived from cycles since sequence start).
module tb_rst_seq_ctrl;
  localparam int P_D [2] = '{2, 3};
  localparam int P_N [2] = '{4, 1};
  localparam int P_H [2] = '{8, 1};
  localparam int P_G [2] = '{16, 1};
  logic       clk = 1'b0;
  logic [1:0] rz  = 2'b00;
  logic [1:0] rq  = 2'b00;
  logic [1:0] ack_w, rdy_w, busy_w;
  logic [3:0] rst0;
  logic [0:0] rst1;
  int n_chk = 0;
  int n_pass = 0;
  int sc [2] = '{0, 0};
  int t [2] = '{-1, -1};
  bit m_ack [2] = '{0, 0};
  bit m_pend [2] = '{0, 0};
  rst_seq_ctrl u_dut0 (.clk(clk), .rstz(rz[0]), .sw_req(rq[0]), .sw_ack(ack_w[0]),
    .rst_out_n(rst0), .busy(busy_w[0]), .ready(rdy_w[0]));
  rst_seq_ctrl #(.DEPTH(3), .NUM_RST(1), .HOLD(1), .GAP(1)) u_dut1 (.clk(clk), .rstz(rz[1]),
    .sw_req(rq[1]), .sw_ack(ack_w[1]), .rst_out_n(rst1), .busy(busy_w[1]), .ready(rdy_w[1]));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
  endtask
  function automatic int t_run(input int i);
    return P_H[i] + P_N[i] * P_G[i];
  endfunction
  function automatic int exp_rst(input int i);
    int e = 0;
    for (int k = 0; k < P_N[i]; k++) if (t[i] >= P_H[i] + k * P_G[i]) e |= 1 << k;
    return e;
  endfunction
  function automatic void mreset(input int i);
    sc[i] = 0; t[i] = -1; m_ack[i] = 0; m_pend[i] = 0;
  endfunction
  function automatic void step(input int i);
    if (!rz[i]) return;
    if (sc[i] < P_D[i]) begin
      sc[i]++;
      if (sc[i] == P_D[i]) t[i] = 0;
    end else if (t[i] >= t_run(i) && rq[i] && !m_ack[i]) begin
      t[i] = 0;
      m_pend[i] = 1;
    end else begin
      if (m_ack[i] && !rq[i]) m_ack[i] = 0;
      t[i]++;
      if (t[i] == t_run(i) && m_pend[i]) begin
        m_ack[i] = 1;
        m_pend[i] = 0;
      end
    end
  endfunction
  task automatic chk_all(input int i);
    check($sformatf("rst_out_n%0d", i), i == 0 ? int'(rst0) : int'(rst1), exp_rst(i));
    check($sformatf("ready%0d", i), int'(rdy_w[i]), int'(t[i] >= t_run(i)));
    check($sformatf("busy%0d", i), int'(busy_w[i]), int'(t[i] < t_run(i)));
    check($sformatf("sw_ack%0d", i), int'(ack_w[i]), int'(m_ack[i]));
  endtask
  always @(posedge clk) for (int i = 0; i < 2; i++) step(i);
  always @(negedge clk) for (int i = 0; i < 2; i++) chk_all(i);
  task automatic areset(input int i, input int ncyc);
    @(negedge clk);
    #2;
    rz[i] = 1'b0;
    mreset(i);
    #1;
    chk_all(i);
    if (ncyc == 0) begin
      rz[i] = 1'b1;
      #1;
      chk_all(i);
    end else begin
      repeat (ncyc) @(negedge clk);
      #2;
      rz[i] = 1'b1;
    end
  endtask
  task automatic handshake(input int i);
    int n = 0;
    @(negedge clk);
    rq[i] = 1'b1;
    while (!ack_w[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n == 400) check($sformatf("ack_wait%0d", i), int'(ack_w[i]), 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rq[i] = 1'b0;
  endtask
  task automatic run_inst(input int i);
    repeat (5) @(negedge clk);
    #2;
    rz[i] = 1'b1;
    repeat (t_run(i) + 8) @(negedge clk);
    handshake(i);
    repeat (t_run(i) / 2 + 5) @(negedge clk);
    areset(i, 3);
    repeat (t_run(i) + 8) @(negedge clk);
    areset(i, 0);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(1, 100)) @(negedge clk);
        1: begin
          @(negedge clk);
          rq[i] = 1'b1;
          repeat ($urandom_range(1, 150)) @(negedge clk);
          rq[i] = 1'b0;
        end
        2: handshake(i);
        default: areset(i, $urandom_range(0, 4));
      endcase
    end
    rq[i] = 1'b0;
    repeat (t_run(i) + 10) @(negedge clk);
  endtask
  initial begin
    fork
      run_inst(0);
      run_inst(1);
    join
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
